// File: rtl/fmul_float_result_pack.sv
// fmul_float_result_pack: packs the normalized/rounded FMUL result into an
// IEEE-754 single word and buffers it in a 2-entry valid/busy FIFO.
// Ports:
//   iCLOCK, inRESET (async, active-low), iRESET_SYNC (sync clear)
//   iDATA_VALID/oDATA_BUSY  upstream handshake
//   iDATA_SIGN/EXP/FRACT and iDATA_EXCEPT_*  result fields and operand classes
//   oDATA_VALID/iDATA_BUSY  downstream handshake
//   oDATA_RESULT, oFLAG_OVERFLOW/UNDERFLOW/INVALID  head entry of the FIFO
// Optional macro FMUL_FLOAT_STICKY_FLAG_EN adds iSTICKY_CLEAR and
// oSTICKY_FLAGS = {invalid, underflow, overflow} accumulated on each pop.
module fmul_float_result_pack (
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iRESET_SYNC,
   input  logic        iDATA_VALID,
   output logic        oDATA_BUSY,
   input  logic        iDATA_SIGN,
   input  logic [9:0]  iDATA_EXP,
   input  logic [23:0] iDATA_FRACT,
   input  logic        iDATA_EXCEPT_EXP_A0,
   input  logic        iDATA_EXCEPT_EXP_B0,
   input  logic        iDATA_EXCEPT_EXP_A1,
   input  logic        iDATA_EXCEPT_EXP_B1,
   input  logic        iDATA_EXCEPT_FRACT_A0,
   input  logic        iDATA_EXCEPT_FRACT_B0,
   output logic        oDATA_VALID,
   input  logic        iDATA_BUSY,
   output logic [31:0] oDATA_RESULT,
   output logic        oFLAG_OVERFLOW,
   output logic        oFLAG_UNDERFLOW,
   output logic        oFLAG_INVALID
`ifdef FMUL_FLOAT_STICKY_FLAG_EN
  ,input  logic        iSTICKY_CLEAR,
   output logic [2:0]  oSTICKY_FLAGS
`endif
);

   logic        is_nan;
   logic        is_inf;
   logic        is_zero;
   logic        is_ovf;
   logic        is_unf;
   logic [31:0] pk_res;
   logic        pk_ovf;
   logic        pk_unf;
   logic        pk_inv;

   // Entry layout: {result[31:0], overflow, underflow, invalid}
   logic [34:0] mem_q [2];
   logic [1:0]  cnt_q, cnt_d;
   logic        wptr_q, wptr_d;
   logic        rptr_q, rptr_d;
   logic        push;
   logic        pop;
   logic [34:0] head;

   always_comb begin
      is_nan  = (iDATA_EXCEPT_EXP_A1 & ~iDATA_EXCEPT_FRACT_A0)
              | (iDATA_EXCEPT_EXP_B1 & ~iDATA_EXCEPT_FRACT_B0)
              | (iDATA_EXCEPT_EXP_A1 & iDATA_EXCEPT_EXP_B0)
              | (iDATA_EXCEPT_EXP_B1 & iDATA_EXCEPT_EXP_A0);
      is_inf  = iDATA_EXCEPT_EXP_A1 | iDATA_EXCEPT_EXP_B1;
      is_zero = iDATA_EXCEPT_EXP_A0 | iDATA_EXCEPT_EXP_B0;
      // exponent is two's complement: bit9 set means negative
      is_ovf  = ~iDATA_EXP[9] & (iDATA_EXP[8:0] >= 9'd255);
      is_unf  = iDATA_EXP[9] | (iDATA_EXP == 10'd0);
   end

   always_comb begin
      pk_res = {iDATA_SIGN, iDATA_EXP[7:0], iDATA_FRACT[22:0]};
      pk_ovf = 1'b0;
      pk_unf = 1'b0;
      pk_inv = 1'b0;
      if (is_nan) begin
         pk_res = 32'h7FC0_0000;
         pk_inv = 1'b1;
      end else if (is_inf) begin
         pk_res = {iDATA_SIGN, 8'hFF, 23'h0};
      end else if (is_zero) begin
         pk_res = {iDATA_SIGN, 31'h0};
      end else if (is_ovf) begin
         pk_res = {iDATA_SIGN, 8'hFF, 23'h0};
         pk_ovf = 1'b1;
      end else if (is_unf) begin
         pk_res = {iDATA_SIGN, 31'h0};
         pk_unf = 1'b1;
      end
   end

   // Busy/valid come straight from the count register; no path from iDATA_BUSY
   assign oDATA_BUSY  = (cnt_q == 2'd2);
   assign oDATA_VALID = (cnt_q != 2'd0);

   assign push = iDATA_VALID & ~oDATA_BUSY;
   assign pop  = oDATA_VALID & ~iDATA_BUSY;

   always_comb begin
      cnt_d  = cnt_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (push) begin
         wptr_d = ~wptr_q;
      end
      if (pop) begin
         rptr_d = ~rptr_q;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + 2'd1;
         2'b01:   cnt_d = cnt_q - 2'd1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         cnt_q    <= 2'd0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         mem_q[0] <= 35'h0;
         mem_q[1] <= 35'h0;
      end else if (iRESET_SYNC) begin
         cnt_q    <= 2'd0;
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         mem_q[0] <= 35'h0;
         mem_q[1] <= 35'h0;
      end else begin
         cnt_q  <= cnt_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         if (push) begin
            mem_q[wptr_q] <= {pk_res, pk_ovf, pk_unf, pk_inv};
         end
      end
   end

   assign head            = mem_q[rptr_q];
   assign oDATA_RESULT    = head[34:3];
   assign oFLAG_OVERFLOW  = head[2];
   assign oFLAG_UNDERFLOW = head[1];
   assign oFLAG_INVALID   = head[0];

`ifdef FMUL_FLOAT_STICKY_FLAG_EN
   logic [2:0] sticky_q, sticky_d;

   // A flag popped in the same cycle as a clear still gets recorded
   always_comb begin
      sticky_d = (iSTICKY_CLEAR ? 3'b000 : sticky_q)
               | (pop ? {head[0], head[1], head[2]} : 3'b000);
   end

   always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
         sticky_q <= 3'b000;
      end else if (iRESET_SYNC) begin
         sticky_q <= 3'b000;
      end else begin
         sticky_q <= sticky_d;
      end
   end

   assign oSTICKY_FLAGS = sticky_q;
`endif

endmodule

// File: tb/tb_fmul_float_result_pack.sv
// Directed-vector bench for fmul_float_result_pack.
// Checks packing cases, FIFO stall/stream behaviour and both resets.
module tb_fmul_float_result_pack;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rsync = 1'b0;
   logic        ivalid = 1'b0;
   logic        obusy;
   logic        sign = 1'b0;
   logic [9:0]  exp = 10'h0;
   logic [23:0] fract = 24'h0;
   logic        a0 = 1'b0, b0 = 1'b0, a1 = 1'b0, b1 = 1'b0;
   logic        fa0 = 1'b0, fb0 = 1'b0;
   logic        ovalid;
   logic        ibusy = 1'b0;
   logic [31:0] res;
   logic        f_ovf, f_unf, f_inv;
`ifdef FMUL_FLOAT_STICKY_FLAG_EN
   logic        sclr = 1'b0;
   logic [2:0]  sticky;
`endif

   int nvec = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   fmul_float_result_pack dut (
      .iCLOCK                (clk),
      .inRESET               (rst_n),
      .iRESET_SYNC           (rsync),
      .iDATA_VALID           (ivalid),
      .oDATA_BUSY            (obusy),
      .iDATA_SIGN            (sign),
      .iDATA_EXP             (exp),
      .iDATA_FRACT           (fract),
      .iDATA_EXCEPT_EXP_A0   (a0),
      .iDATA_EXCEPT_EXP_B0   (b0),
      .iDATA_EXCEPT_EXP_A1   (a1),
      .iDATA_EXCEPT_EXP_B1   (b1),
      .iDATA_EXCEPT_FRACT_A0 (fa0),
      .iDATA_EXCEPT_FRACT_B0 (fb0),
      .oDATA_VALID           (ovalid),
      .iDATA_BUSY            (ibusy),
      .oDATA_RESULT          (res),
      .oFLAG_OVERFLOW        (f_ovf),
      .oFLAG_UNDERFLOW       (f_unf),
      .oFLAG_INVALID         (f_inv)
`ifdef FMUL_FLOAT_STICKY_FLAG_EN
     ,.iSTICKY_CLEAR         (sclr),
      .oSTICKY_FLAGS         (sticky)
`endif
   );

   typedef struct {
      logic        s;
      logic [9:0]  e;
      logic [23:0] f;
      logic [5:0]  ex;   // {a0,b0,a1,b1,fa0,fb0}
      logic [31:0] r;
      logic [2:0]  fl;   // {ovf,unf,inv}
   } vec_t;

   vec_t vt [13];

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      nvec++;
      assert (obs === expv) else begin
         nerr++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic s, input logic [9:0] e,
                        input logic [23:0] f, input logic [5:0] ex);
      sign  = s;
      exp   = e;
      fract = f;
      {a0, b0, a1, b1, fa0, fb0} = ex;
   endtask

   initial begin
      vt[0]  = '{1'b0, 10'h07F, 24'hC00000, 6'b000000, 32'h3FC00000, 3'b000};
      vt[1]  = '{1'b0, 10'h100, 24'h800000, 6'b000000, 32'h7F800000, 3'b100};
      vt[2]  = '{1'b1, 10'h3FE, 24'h800000, 6'b000000, 32'h80000000, 3'b010};
      vt[3]  = '{1'b0, 10'h07F, 24'h800000, 6'b011011, 32'h7FC00000, 3'b001};
      vt[4]  = '{1'b1, 10'h07F, 24'h800000, 6'b001010, 32'hFF800000, 3'b000};
      vt[5]  = '{1'b0, 10'h07F, 24'h800000, 6'b001000, 32'h7FC00000, 3'b001};
      vt[6]  = '{1'b1, 10'h080, 24'h800000, 6'b010001, 32'h80000000, 3'b000};
      vt[7]  = '{1'b0, 10'h000, 24'h800000, 6'b000000, 32'h00000000, 3'b010};
      vt[8]  = '{1'b0, 10'h0FE, 24'hFFFFFF, 6'b000000, 32'h7F7FFFFF, 3'b000};
      vt[9]  = '{1'b1, 10'h0FF, 24'h800000, 6'b000000, 32'hFF800000, 3'b100};
      vt[10] = '{1'b0, 10'h001, 24'h800000, 6'b000000, 32'h00800000, 3'b000};
      vt[11] = '{1'b0, 10'h1FF, 24'h800000, 6'b000000, 32'h7F800000, 3'b100};
      vt[12] = '{1'b1, 10'h200, 24'h800000, 6'b000000, 32'h80000000, 3'b010};

      // reset state
      #3;
      chk("rst_valid", {31'h0, ovalid}, 32'h0);
      chk("rst_busy", {31'h0, obusy}, 32'h0);
      chk("rst_result", res, 32'h0);
      chk("rst_flags", {29'h0, f_ovf, f_unf, f_inv}, 32'h0);
`ifdef FMUL_FLOAT_STICKY_FLAG_EN
      chk("rst_sticky", {29'h0, sticky}, 32'h0);
`endif
      tick();
      rst_n = 1'b1;
      tick();

      // packing vectors, one at a time through the FIFO
      for (int i = 0; i < 13; i++) begin
         drive(vt[i].s, vt[i].e, vt[i].f, vt[i].ex);
         ivalid = 1'b1;
         tick();
         ivalid = 1'b0;
         chk($sformatf("pk%0d_valid", i), {31'h0, ovalid}, 32'h1);
         chk($sformatf("pk%0d_result", i), res, vt[i].r);
         chk($sformatf("pk%0d_flags", i),
             {29'h0, f_ovf, f_unf, f_inv}, {29'h0, vt[i].fl});
         tick();
         chk($sformatf("pk%0d_drain", i), {31'h0, ovalid}, 32'h0);
      end

      // data without valid is ignored
      drive(1'b0, 10'h07F, 24'hC00000, 6'b000000);
      tick();
      chk("novalid", {31'h0, ovalid}, 32'h0);

      // stall with three back-to-back inputs
      ibusy = 1'b1;
      drive(1'b0, 10'h080, 24'h800000, 6'b000000);
      ivalid = 1'b1;
      tick();
      chk("st1_valid", {31'h0, ovalid}, 32'h1);
      chk("st1_busy", {31'h0, obusy}, 32'h0);
      chk("st1_result", res, 32'h40000000);
      drive(1'b0, 10'h081, 24'h800000, 6'b000000);
      tick();
      chk("st2_busy", {31'h0, obusy}, 32'h1);
      chk("st2_result", res, 32'h40000000);
      drive(1'b0, 10'h082, 24'h800000, 6'b000000);
      tick();
      chk("st3_busy", {31'h0, obusy}, 32'h1);
      chk("st3_result", res, 32'h40000000);
      tick();
      chk("st3_hold", res, 32'h40000000);
      ibusy = 1'b0;
      tick();
      chk("rel1_result", res, 32'h40800000);
      chk("rel1_busy", {31'h0, obusy}, 32'h0);
      tick();
      ivalid = 1'b0;
      chk("rel2_result", res, 32'h41000000);
      chk("rel2_valid", {31'h0, ovalid}, 32'h1);
      tick();
      chk("rel3_valid", {31'h0, ovalid}, 32'h0);

      // streaming at count 1
      drive(1'b0, 10'h070, 24'h800000, 6'b000000);
      ivalid = 1'b1;
      tick();
      for (int i = 1; i <= 10; i++) begin
         drive(1'b0, 10'h070 + 10'(i), 24'h800000, 6'b000000);
         tick();
         chk($sformatf("strm%0d_result", i), res,
             {1'b0, 8'(8'h70 + i), 23'h0});
         chk($sformatf("strm%0d_cnt1", i), {30'h0, obusy, ovalid}, 32'h1);
      end
      ivalid = 1'b0;
      tick();
      chk("strm_drain", {31'h0, ovalid}, 32'h0);

      // synchronous clear with two entries held
      ibusy = 1'b1;
      drive(1'b0, 10'h085, 24'h800000, 6'b000000);
      ivalid = 1'b1;
      tick();
      tick();
      chk("sr_full", {31'h0, obusy}, 32'h1);
      rsync = 1'b1;
      ibusy = 1'b0;
      tick();
      rsync = 1'b0;
      ivalid = 1'b0;
      chk("sr_valid", {31'h0, ovalid}, 32'h0);
      chk("sr_busy", {31'h0, obusy}, 32'h0);
      chk("sr_result", res, 32'h0);

      // asynchronous reset in the middle of a cycle
      ibusy = 1'b1;
      drive(1'b1, 10'h07F, 24'h800000, 6'b000000);
      ivalid = 1'b1;
      tick();
      ivalid = 1'b0;
      chk("ar_pre", res, 32'hBF800000);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_valid", {31'h0, ovalid}, 32'h0);
      chk("ar_result", res, 32'h0);
      tick();
      rst_n = 1'b1;
      ibusy = 1'b0;
      tick();

`ifdef FMUL_FLOAT_STICKY_FLAG_EN
      drive(1'b0, 10'h100, 24'h800000, 6'b000000);
      ivalid = 1'b1;
      tick();
      ivalid = 1'b0;
      tick();
      drive(1'b0, 10'h07F, 24'h800000, 6'b000000);
      ivalid = 1'b1;
      tick();
      ivalid = 1'b0;
      tick();
      chk("sticky_ovf", {29'h0, sticky}, 32'h1);
      drive(1'b0, 10'h07F, 24'h800000, 6'b011011);
      ivalid = 1'b1;
      tick();
      ivalid = 1'b0;
      sclr = 1'b1;
      tick();
      sclr = 1'b0;
      chk("sticky_clr_inv", {29'h0, sticky}, 32'h4);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fmul_float_result_pack.md
FMUL_FLOAT_RESULT_PACK -- requirements
Module: fmul_float_result_pack

Interface
REQ-001 The block SHALL have the following ports; it SHALL NOT have parameters.
- iCLOCK  in  1  clock, rising edge
- inRESET  in  1  asynchronous, active-low reset
- iRESET_SYNC  in  1  synchronous clear, active-high
- iDATA_VALID  in  1  upstream normalized/rounded result valid
- oDATA_BUSY  out  1  back-pressure to upstream
- iDATA_SIGN  in  1  result sign
- iDATA_EXP  in  10  two's-complement biased exponent
- iDATA_FRACT  in  24  normalized mantissa, bit23 = hidden 1
- iDATA_EXCEPT_EXP_A0/B0  in  1 each  operand exponent all-zero
- iDATA_EXCEPT_EXP_A1/B1  in  1 each  operand exponent all-one
- iDATA_EXCEPT_FRACT_A0/B0  in  1 each  operand fraction all-zero
- oDATA_VALID  out  1  packed result valid
- iDATA_BUSY  in  1  downstream stall
- oDATA_RESULT  out  32  IEEE-754 single result
- oFLAG_OVERFLOW/oFLAG_UNDERFLOW/oFLAG_INVALID  out  1 each  per-result flags
- iSTICKY_CLEAR  in  1  clear sticky flags (macro only)
- oSTICKY_FLAGS  out  3  {invalid, underflow, overflow} (macro only)
REQ-002 Reset SHALL be inRESET, asynchronous, active-low; clock SHALL be iCLOCK.

Function
REQ-003 Packing SHALL be combinational from the inputs, in this priority order:
- NaN: (A1&!FRACT_A0)|(B1&!FRACT_B0)|(A1&B0)|(B1&A0) -> 0x7FC00000, INVALID=1.
- Infinity: A1|B1 -> {sign,0xFF,0}.
- Zero: A0|B0 -> {sign,31'h0}; denormal operands flush to zero.
- Overflow: EXP bit9=0 and EXP>=255 -> {sign,0xFF,0}, OVERFLOW=1.
- Underflow: EXP bit9=1 or EXP==0 -> {sign,31'h0}, UNDERFLOW=1.
- Normal: {sign,EXP[7:0],FRACT[22:0]}.
REQ-004 Packed entries SHALL be stored in a 2-entry FIFO (result+3 flags) with a 2-bit count register (0..2).
REQ-005 Push SHALL occur on a rising edge when iDATA_VALID=1 and oDATA_BUSY=0; pop SHALL occur when oDATA_VALID=1 and iDATA_BUSY=0.
REQ-006 oDATA_BUSY SHALL equal (count==2) and SHALL be decoded from registers only, with no combinational path from iDATA_BUSY.
REQ-007 oDATA_VALID SHALL equal (count!=0); oDATA_RESULT and the flags SHALL present the head entry.
REQ-008 Latency from an accepted push into an empty FIFO to oDATA_VALID SHALL be 1 cycle.
REQ-009 Count SHALL update as follows:
- Simultaneous push and pop at count 1: count stays 1; the new entry becomes head on the next cycle.
- Push at count 0 together with iDATA_BUSY=1: count becomes 1.
REQ-010 Read and write pointers SHALL each be 1 bit and SHALL wrap from 1 to 0.
REQ-011 Entry contents SHALL remain stable while oDATA_VALID=1 and iDATA_BUSY=1.
REQ-012 Input with iDATA_VALID=0 SHALL NOT be stored, regardless of data values.

Reset
REQ-013 When inRESET=0, count, pointers, sticky flags and all outputs SHALL go to 0 immediately: oDATA_VALID=0, oDATA_BUSY=0, oDATA_RESULT=0, all flags 0.
REQ-014 iRESET_SYNC=1 SHALL clear the same state at the next edge, overriding any push or pop, including mid-stall with 2 entries held.

Configuration
REQ-015 With FMUL_FLOAT_STICKY_FLAG_EN defined, iSTICKY_CLEAR and oSTICKY_FLAGS SHALL exist. On each edge, sticky_next = (iSTICKY_CLEAR ? 0 : sticky) | (pop ? head flags : 0); a same-cycle pop flag survives a clear.
REQ-016 With FMUL_FLOAT_STICKY_FLAG_EN undefined, those ports and the sticky register SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-017 Normal: SIGN=0, EXP=0x07F, FRACT=0xC00000, no exceptions, iDATA_BUSY=0 -> next cycle oDATA_VALID=1, RESULT=0x3FC00000, flags 0.
REQ-018 Special cases: EXP=0x100 -> 0x7F800000 with OVERFLOW; EXP=0x3FE, SIGN=1 -> 0x80000000 with UNDERFLOW; A1 & B0 -> 0x7FC00000 with INVALID.
REQ-019 Stall: iDATA_BUSY=1 with 3 back-to-back valid inputs -> the first two are stored, oDATA_BUSY=1 from the 2nd edge; release -> outputs pop in order and the 3rd input is accepted once oDATA_BUSY=0.
REQ-020 Streaming: count=1 with continuous push and pop for 10 cycles -> count stays 1, no loss, order preserved.
REQ-021 Reset: iRESET_SYNC pulsed with 2 entries held -> next cycle oDATA_VALID=0, oDATA_BUSY=0; asynchronous inRESET mid-cycle -> outputs 0 before the next edge.
REQ-022 Sticky (macro on): pop overflow, then pop a normal result -> oSTICKY_FLAGS=3'b001; iSTICKY_CLEAR together with an INVALID pop -> 3'b100.
